// File: rtl/reg_dump_reader_g7.sv
// Register-file dump sequencer: walks x0..NREGS-1 through a one-cycle-latency
// register-file read port and presents each value on a valid/ready stream.
module reg_dump_reader_g7 #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_idx,
    output logic [XLEN-1:0] out_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] idx;
    logic       xfer;

    assign xfer = (state == ST_SEND) && out_ready;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_SEND;
            ST_SEND: begin
                if (xfer) state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_READ;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (state == ST_IDLE && start) begin
            idx <= '0;
        end else if (xfer && idx != LAST_IDX) begin
            idx <= idx + 5'd1;
        end
    end

    // Read data is captured in LATCH, one cycle after the address was issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_idx  <= '0;
            out_data <= '0;
        end else if (state == ST_LATCH) begin
            out_idx  <= idx;
            out_data <= rf_rdata;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign out_valid = (state == ST_SEND);
    assign rf_raddr  = (state == ST_READ || state == ST_LATCH) ? idx : 5'd0;

endmodule

// File: tb/tb_reg_dump_reader_g7.sv
// Scoreboard bench for reg_dump_reader_g7: directed dumps against a registered
// register-file model whose contents are xN = N*0x11 ^ salt.
module tb_reg_dump_reader_g7;

    localparam int NREGS = 32;
    localparam int XLEN  = 32;

    typedef struct {
        logic [4:0]      idx;
        logic [XLEN-1:0] data;
    } elem_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4:0]      out_idx;
    logic [XLEN-1:0] out_data;

    elem_t     exp_q[$];
    int        n_cmp = 0;
    int        n_err = 0;
    int        cyc = 0;
    int        xfer_count = 0;
    int        done_count = 0;
    logic      done_prev = 1'b0;
    logic [XLEN-1:0] salt = '0;

    reg_dump_reader_g7 #(.NREGS(NREGS), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] reg_val(input logic [4:0] a);
        return (XLEN'(a) * 32'h11) ^ salt;
    endfunction

    // Register file: data appears one cycle after the address.
    always @(posedge clk) begin
        rf_rdata <= reg_val(rf_raddr);
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs only change 1ns after a rising edge, so the values seen
    // here are the ones the DUT samples at the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 64'd1, 64'd0);
            end else begin
                elem_t e;
                e = exp_q.pop_front();
                check("xfer_idx", 64'(out_idx), 64'(e.idx));
                check("xfer_data", 64'(out_data), 64'(e.data));
            end
            xfer_count++;
        end
        if (done) begin
            done_count++;
            check("done_single_cycle", 64'(done_prev), 64'd0);
        end
        done_prev <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(output int k);
        for (int i = 0; i < NREGS; i++) begin
            elem_t e;
            e.idx  = 5'(i);
            e.data = reg_val(5'(i));
            exp_q.push_back(e);
        end
        xfer_count = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc;
    endtask

    task automatic wait_raddr(input string name, input logic [4:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (busy && !out_valid && rf_raddr == a) found = 1'b1;
        end
        check(name, 64'(found), 64'd1);
    endtask

    task automatic wait_done(input string name, output int at);
        logic found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            if (done) found = 1'b1;
            else tick();
        end
        if (found) at = cyc;
        check(name, 64'(found), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int t_done;
        int dc;

        // Reset state
        #2 rst = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_raddr", 64'(rf_raddr), 0);
        check("rst_out_idx", 64'(out_idx), 0);
        check("rst_out_data", 64'(out_data), 0);
        rst = 1'b1;

        // Idle with out_ready toggling: nothing may move
        for (int i = 0; i < 50; i++) begin
            out_ready = ~out_ready;
            tick();
            check("idle_quiet", 64'({out_valid, done, busy, rf_raddr, out_idx}), 0);
        end

        // Full dump with constant ready; latency and read-latency alignment
        out_ready = 1'b1;
        start_dump(k);
        check("d1_busy_read", 64'(busy), 1);
        check("d1_valid_read", 64'(out_valid), 0);
        check("d1_raddr_read", 64'(rf_raddr), 0);
        tick();
        check("d1_valid_latch", 64'(out_valid), 0);
        tick();
        check("d1_valid_send", 64'(out_valid), 1);
        check("d1_idx_send", 64'(out_idx), 0);
        wait_done("d1_done_seen", t_done);
        check("d1_done_latency", 64'(t_done - k), 96);
        check("d1_busy_in_done", 64'(busy), 1);
        check("d1_valid_in_done", 64'(out_valid), 0);
        check("d1_raddr_in_done", 64'(rf_raddr), 0);
        tick();
        check("d1_done_fall", 64'(done), 0);
        check("d1_busy_fall", 64'(busy), 0);
        check("d1_xfers", 64'(xfer_count), 32);
        check("d1_queue_empty", 64'(exp_q.size()), 0);

        // Backpressure on element 7
        salt = 32'hA5A5_0000;
        start_dump(k);
        wait_raddr("d2_reach_7", 5'd7);
        out_ready = 1'b0;
        tick();
        check("d2_raddr_latch", 64'(rf_raddr), 7);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("d2_hold_valid", 64'(out_valid), 1);
            check("d2_hold_idx", 64'(out_idx), 7);
            check("d2_hold_data", 64'(out_data), 64'(reg_val(5'd7)));
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("d2_after_valid", 64'(out_valid), 0);
        check("d2_after_raddr", 64'(rf_raddr), 8);
        wait_done("d2_done_seen", t_done);
        tick();
        check("d2_xfers", 64'(xfer_count), 32);
        check("d2_queue_empty", 64'(exp_q.size()), 0);

        // Spurious start while busy and during DONE
        salt = 32'h0F0F_1234;
        repeat (2) tick();
        dc = done_count;
        start_dump(k);
        wait_raddr("d3_reach_3", 5'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("d3_done_seen", t_done);
        check("d3_done_latency", 64'(t_done - k), 96);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("d3_no_restart", 64'({busy, out_valid}), 0);
            tick();
        end
        check("d3_xfers", 64'(xfer_count), 32);
        check("d3_single_done", 64'(done_count - dc), 1);
        check("d3_queue_empty", 64'(exp_q.size()), 0);

        // Reset mid-dump while element 12 is waiting
        salt = 32'h3C00_00C3;
        dc = done_count;
        start_dump(k);
        wait_raddr("d4_reach_12", 5'd12);
        out_ready = 1'b0;
        repeat (2) tick();
        check("d4_valid_pre_rst", 64'(out_valid), 1);
        rst = 1'b0;
        #1;
        check("d4_async_valid", 64'(out_valid), 0);
        check("d4_async_busy", 64'(busy), 0);
        check("d4_async_outs", 64'({out_idx, out_data}), 0);
        check("d4_partial_xfers", 64'(xfer_count), 12);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("d4_wait_start", 64'({busy, out_valid, done}), 0);
        end
        check("d4_no_done", 64'(done_count - dc), 0);

        // Fresh dump after reset starts at index 0
        salt = 32'h5555_AAAA;
        start_dump(k);
        wait_done("d5_done_seen", t_done);
        check("d5_done_latency", 64'(t_done - k), 96);
        tick();
        check("d5_xfers", 64'(xfer_count), 32);
        check("d5_queue_empty", 64'(exp_q.size()), 0);
        check("d5_single_done", 64'(done_count - dc), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
